// File: rtl/keypad_pkg.sv
// keypad_pkg: shared types and helpers for the 4x4 keypad scanner.
//   - state_e       : scanner FSM states (2 bits)
//   - ROWS_IDLE     : row pattern with no active (low) row
//   - key_lookup    : (row index, column index) -> 4-bit hex key code
//   - count_active  : number of active-low rows in a row pattern
//   - onehot_index  : index of the active-low row in a single-active pattern
package keypad_pkg;

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_PRESSED  = 2'd2,
    ST_RELEASE  = 2'd3
  } state_e;

  localparam logic [3:0] ROWS_IDLE = 4'b1111;

  // Physical keypad legend, row-major:
  //   r0: 1 2 3 A   r1: 4 5 6 B   r2: 7 8 9 C   r3: E 0 F D
  function automatic logic [3:0] key_lookup(input logic [1:0] row_idx,
                                            input logic [1:0] col_idx);
    logic [3:0] code;
    code = 4'h0;
    case ({row_idx, col_idx})
      4'h0: code = 4'h1;
      4'h1: code = 4'h2;
      4'h2: code = 4'h3;
      4'h3: code = 4'hA;
      4'h4: code = 4'h4;
      4'h5: code = 4'h5;
      4'h6: code = 4'h6;
      4'h7: code = 4'hB;
      4'h8: code = 4'h7;
      4'h9: code = 4'h8;
      4'hA: code = 4'h9;
      4'hB: code = 4'hC;
      4'hC: code = 4'hE;
      4'hD: code = 4'h0;
      4'hE: code = 4'hF;
      4'hF: code = 4'hD;
      default: code = 4'h0;
    endcase
    return code;
  endfunction

  function automatic logic [2:0] count_active(input logic [3:0] rows_n);
    logic [2:0] n;
    n = 3'd0;
    for (int i = 0; i < 4; i++) begin
      if (!rows_n[i]) n = n + 3'd1;
    end
    return n;
  endfunction

  // Only meaningful when exactly one row is active; the lowest active
  // index wins otherwise.
  function automatic logic [1:0] onehot_index(input logic [3:0] rows_n);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!rows_n[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/keypad_scanner_row_sync.sv
// row_sync: two-flop synchronizer for the asynchronous keypad row inputs.
//   clk      in  system clock
//   reset_n  in  asynchronous active-low reset (flops reset to all-ones = idle)
//   row_n    in  [3:0] raw active-low rows from the pins
//   row_s    out [3:0] synchronized rows
module row_sync (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] row_n,
  output logic [3:0] row_s
);

  logic [3:0] sync1_d, sync1_q;
  logic [3:0] sync2_d, sync2_q;

  always_comb begin
    sync1_d = row_n;
    sync2_d = sync1_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 4'b1111;
      sync2_q <= 4'b1111;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  assign row_s = sync2_q;

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x4 matrix keypad, debounces press and release,
// and reports one hex key code per press.
//   clk        in  system clock
//   reset_n    in  asynchronous active-low reset
//   row_n      in  [3:0] keypad rows, active-low, asynchronous, pulled up
//   col_n      out [3:0] column drive, active-low, exactly one bit low
//   key_valid  out one-cycle strobe when a debounced key is accepted
//   key_code   out [3:0] code of the last accepted key (held until next)
//   key_held   out high while the accepted key remains pressed
//
// Handshake: key_valid is a pure strobe with no back-pressure; a consumer
// must capture key_code in the cycle key_valid is high (key_code is also
// held afterwards until the next accept).
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV        = 16,    // cycles per column, >= 4
  parameter int DEBOUNCE_CYCLES = 50000  // stable cycles to accept, >= 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] row_n,
  output logic [3:0] col_n,
  output logic       key_valid,
  output logic [3:0] key_code,
  output logic       key_held
);

  localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);

  logic [3:0] row_s;

  row_sync u_row_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .row_n   (row_n),
    .row_s   (row_s)
  );

  state_e            state_d,     state_q;
  logic [SCAN_W-1:0] scan_cnt_d,  scan_cnt_q;
  logic [DB_W-1:0]   db_cnt_d,    db_cnt_q;
  logic [1:0]        col_idx_d,   col_idx_q;
  logic [3:0]        row_pat_d,   row_pat_q;
  logic              key_valid_d, key_valid_q;
  logic [3:0]        key_code_d,  key_code_q;
  logic              key_held_d,  key_held_q;

  always_comb begin
    state_d     = state_q;
    scan_cnt_d  = scan_cnt_q;
    db_cnt_d    = db_cnt_q;
    col_idx_d   = col_idx_q;
    row_pat_d   = row_pat_q;
    key_valid_d = 1'b0;
    key_code_d  = key_code_q;
    key_held_d  = key_held_q;

    case (state_q)
      ST_SCAN: begin
        // Rows are only looked at in the last cycle of a column slot so the
        // column drive has settled and passed through the synchronizer.
        if (scan_cnt_q == SCAN_LAST) begin
          scan_cnt_d = '0;
          if (count_active(row_s) == 3'd1) begin
            row_pat_d = row_s;
            db_cnt_d  = '0;
            state_d   = ST_DEBOUNCE;
          end else begin
            col_idx_d = col_idx_q + 2'd1;
          end
        end else begin
          scan_cnt_d = scan_cnt_q + SCAN_W'(1);
        end
      end

      ST_DEBOUNCE: begin
        if (row_s != row_pat_q) begin
          state_d    = ST_SCAN;
          col_idx_d  = col_idx_q + 2'd1;
          scan_cnt_d = '0;
        end else if (db_cnt_q == DB_LAST) begin
          state_d     = ST_PRESSED;
          key_valid_d = 1'b1;
          key_code_d  = key_lookup(onehot_index(row_pat_q), col_idx_q);
          key_held_d  = 1'b1;
        end else begin
          db_cnt_d = db_cnt_q + DB_W'(1);
        end
      end

      ST_PRESSED: begin
        // A second key in the frozen column changes row_s but is ignored;
        // only a full release moves on.
        if (row_s == ROWS_IDLE) begin
          db_cnt_d = '0;
          state_d  = ST_RELEASE;
        end
      end

      ST_RELEASE: begin
        if (row_s != ROWS_IDLE) begin
          // Release bounce: back to PRESSED without a new strobe.
          state_d = ST_PRESSED;
        end else if (db_cnt_q == DB_LAST) begin
          state_d    = ST_SCAN;
          key_held_d = 1'b0;
          col_idx_d  = col_idx_q + 2'd1;
          scan_cnt_d = '0;
        end else begin
          db_cnt_d = db_cnt_q + DB_W'(1);
        end
      end

      default: state_d = ST_SCAN;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_SCAN;
      scan_cnt_q  <= '0;
      db_cnt_q    <= '0;
      col_idx_q   <= 2'd0;
      row_pat_q   <= ROWS_IDLE;
      key_valid_q <= 1'b0;
      key_code_q  <= 4'h0;
      key_held_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      scan_cnt_q  <= scan_cnt_d;
      db_cnt_q    <= db_cnt_d;
      col_idx_q   <= col_idx_d;
      row_pat_q   <= row_pat_d;
      key_valid_q <= key_valid_d;
      key_code_q  <= key_code_d;
      key_held_q  <= key_held_d;
    end
  end

  assign col_n     = ~(4'b0001 << col_idx_q);
  assign key_valid = key_valid_q;
  assign key_code  = key_code_q;
  assign key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: drives a behavioural 4x4 keypad (a pressed-key set
// wired through whichever column is low) and checks the scanner against
// a transaction-level expectation of reported keys and timing.
module tb_keypad_scanner;

  localparam int SCAN_DIV        = 4;
  localparam int DEBOUNCE_CYCLES = 8;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] row_n;
  logic [3:0] col_n;
  logic       key_valid;
  logic [3:0] key_code;
  logic       key_held;

  always #5 clk = ~clk;

  keypad_scanner #(
    .SCAN_DIV        (SCAN_DIV),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .row_n     (row_n),
    .col_n     (col_n),
    .key_valid (key_valid),
    .key_code  (key_code),
    .key_held  (key_held)
  );

  // ---------------- keypad model ----------------
  // pressed[r*4+c] closes the switch between row r and column c.
  logic [15:0] pressed;
  logic [3:0]  key_tbl [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                                4'h4, 4'h5, 4'h6, 4'hB,
                                4'h7, 4'h8, 4'h9, 4'hC,
                                4'hE, 4'h0, 4'hF, 4'hD};

  always_comb begin
    row_n = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !col_n[c]) row_n[r] = 1'b0;
  end

  // ---------------- scoreboard ----------------
  logic [3:0] exp_q[$];
  int         n_checks  = 0;
  int         n_fail    = 0;
  int         exp_total = 0;
  int         valid_cnt = 0;
  logic [3:0] model_code = 4'h0;
  logic       prev_valid = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic expect_key(input logic [3:0] code);
    exp_q.push_back(code);
    exp_total++;
  endtask

  // Monitor: every strobe must match the next expected key; between
  // strobes key_code must hold; the column drive must stay one-low.
  always @(negedge clk) begin
    if (!reset_n) begin
      model_code = 4'h0;
      prev_valid = 1'b0;
    end else begin
      check("col_onehot", $countones(~col_n), 1);
      if (key_valid) begin
        valid_cnt++;
        if (prev_valid) check("valid_twice", 1, 0);
        if (exp_q.size() == 0) begin
          check("unexpected_valid", key_code, 32'hFF);
          model_code = key_code;
        end else begin
          model_code = exp_q.pop_front();
          check("key_code", key_code, model_code);
        end
      end else if (key_code !== model_code) begin
        check("code_hold", key_code, model_code);
        model_code = key_code;
      end
      prev_valid = key_valid;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Returns at the first negedge after col_n switched to column c, i.e.
  // at the start of that column's slot.
  task automatic wait_col(input int c);
    logic [3:0] m, prev;
    bit ok;
    m = ~(4'b0001 << c);
    prev = col_n;
    ok = 0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (col_n == m && prev != m) ok = 1;
      prev = col_n;
    end
    if (!ok) check("wait_col_timeout", 0, 1);
  endtask

  task automatic wait_valid(input int max, output int lat, output bit seen);
    lat = 0;
    seen = 0;
    for (int i = 0; i < max && !seen; i++) begin
      @(negedge clk);
      lat++;
      if (key_valid) seen = 1;
    end
  endtask

  // Press at the start of column c's slot: the sample is taken in the last
  // slot cycle and the strobe follows DEBOUNCE_CYCLES+1 cycles later, so
  // the strobe is seen SCAN_DIV+DEBOUNCE_CYCLES edges after the press.
  task automatic press_aligned(input int r, input int c);
    int lat;
    bit seen;
    wait_col(c);
    pressed[r*4+c] = 1'b1;
    expect_key(key_tbl[r*4+c]);
    wait_valid(80, lat, seen);
    check("press_seen", seen, 1);
    if (seen) check("press_latency", lat, SCAN_DIV + DEBOUNCE_CYCLES);
    check("held_after_press", key_held, 1);
  endtask

  // Release everything while a key is held: 2 sync edges, 1 edge for
  // PRESSED to see idle rows, then DEBOUNCE_CYCLES idle cycles in RELEASE.
  task automatic release_all(input bit exact);
    int lat;
    bit fell;
    pressed = '0;
    lat = 0;
    fell = 0;
    for (int i = 0; i < 80 && !fell; i++) begin
      @(negedge clk);
      lat++;
      if (!key_held) fell = 1;
    end
    check("release_fell", fell, 1);
    if (exact && fell) check("release_latency", lat, DEBOUNCE_CYCLES + 3);
  endtask

  // ---------------- stimulus ----------------
  int lat, hold, mode, k, k2, cs, d1, d2, win, changes;
  bit seen;
  logic [3:0] pc;

  initial begin
    pressed = '0;
    reset_n = 1'b0;
    tick(3);
    check("rst_col_n", col_n, 4'b1110);
    check("rst_key_valid", key_valid, 0);
    check("rst_key_code", key_code, 4'h0);
    check("rst_key_held", key_held, 0);
    reset_n = 1'b1;
    tick(2);

    // Clean press of key 6 (row1, col2), held ~40 cycles.
    press_aligned(1, 2);
    tick(28);
    check("clean_held", key_held, 1);
    release_all(1);
    tick(3);

    // Press bounce on key A (row0, col3): toggle every 3 cycles, then stable.
    pressed[3] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick(3);
      pressed[3] = ~pressed[3];
    end
    pressed[3] = 1'b1;
    expect_key(4'hA);
    wait_valid(80, lat, seen);
    check("bounce_seen", seen, 1);
    check("bounce_held", key_held, 1);
    tick(5);
    release_all(1);

    // Short glitch on key 0 (row3, col1): 5 cycles only.
    wait_col(1);
    pressed[13] = 1'b1;
    tick(5);
    pressed[13] = 1'b0;
    wait_valid(40, lat, seen);
    check("glitch_no_valid", seen, 0);
    check("glitch_code_kept", key_code, 4'hA);
    pc = col_n;
    changes = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (col_n != pc) changes++;
      pc = col_n;
    end
    check("glitch_scan_resumes", changes >= 4, 1);

    // Two keys in one column (1 and 4, column 0): rejected as ambiguous.
    pressed[0] = 1'b1;
    pressed[4] = 1'b1;
    wait_valid(60, lat, seen);
    check("multi_no_valid", seen, 0);
    pressed[4] = 1'b0;
    expect_key(4'h1);
    wait_valid(60, lat, seen);
    check("multi_key1_seen", seen, 1);
    pressed[1] = 1'b1;  // key 2 in another column while 1 is held
    wait_valid(40, lat, seen);
    check("multi_no_second", seen, 0);
    release_all(1);
    press_aligned(0, 1);
    check("multi_key2_code", key_code, 4'h2);
    release_all(1);

    // Release bounce on key D (row3, col3).
    press_aligned(3, 3);
    for (int i = 0; i < 3; i++) begin
      pressed[15] = 1'b0;
      tick(3);
      check("relbounce_held_a", key_held, 1);
      pressed[15] = 1'b1;
      tick(2);
      check("relbounce_held_b", key_held, 1);
    end
    release_all(1);

    // Reset while PRESSED, key still held afterwards.
    press_aligned(1, 1);
    tick(4);
    reset_n = 1'b0;
    #1;
    check("midrst_col_n", col_n, 4'b1110);
    check("midrst_key_valid", key_valid, 0);
    check("midrst_key_held", key_held, 0);
    check("midrst_key_code", key_code, 4'h0);
    check("midrst_no_pending", exp_q.size(), 0);
    tick(2);
    reset_n = 1'b1;
    expect_key(4'h5);
    wait_valid(80, lat, seen);
    check("midrst_redetect", seen, 1);
    tick(3);
    release_all(1);

    // Randomized presses.
    for (int it = 0; it < 18; it++) begin
      tick($urandom_range(1, 6));
      mode = $urandom_range(0, 2);
      k = $urandom_range(0, 15);
      if (mode == 0) begin
        press_aligned(k / 4, k % 4);
        tick($urandom_range(0, 20));
        release_all(1);
      end else if (mode == 1) begin
        // Active for at most DEBOUNCE_CYCLES synchronized cycles: too short.
        hold = $urandom_range(1, DEBOUNCE_CYCLES);
        pc = key_code;
        wait_col(k % 4);
        pressed[k] = 1'b1;
        tick(hold);
        pressed[k] = 1'b0;
        wait_valid(30, lat, seen);
        check("rand_glitch_no_valid", seen, 0);
        check("rand_glitch_code", key_code, pc);
      end else begin
        // Two keys in different columns: first column reached from the
        // current slot wins.
        k2 = $urandom_range(0, 15);
        while ((k2 % 4) == (k % 4)) k2 = $urandom_range(0, 15);
        cs = $urandom_range(0, 3);
        d1 = ((k % 4) - cs + 4) % 4;
        d2 = ((k2 % 4) - cs + 4) % 4;
        win = (d1 < d2) ? k : k2;
        wait_col(cs);
        pressed[k] = 1'b1;
        pressed[k2] = 1'b1;
        expect_key(key_tbl[win]);
        wait_valid(80, lat, seen);
        check("rand_two_seen", seen, 1);
        tick($urandom_range(0, 10));
        release_all(1);
      end
    end

    tick(20);
    check("pending_empty", exp_q.size(), 0);
    check("valid_total", valid_cnt, exp_total);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog_timeout got=running exp=finished");
    $fatal(1, "watchdog");
  end

endmodule
